// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame geometry, controller state encodings and the
// register map understood by spi_peripheral.
package spi_pkg;

  localparam int SPI_FRAME_W = 16;
  localparam int SPI_ADDR_W  = 7;
  localparam int SPI_DATA_W  = 8;
  localparam int SPI_CNT_W   = 5;

  // Controller FSM state encodings (plain constants for legacy tools).
  typedef logic [2:0] spi_state_t;
  localparam spi_state_t ST_IDLE    = 3'd0;
  localparam spi_state_t ST_SETUP   = 3'd1;
  localparam spi_state_t ST_SCLK_HI = 3'd2;
  localparam spi_state_t ST_SCLK_LO = 3'd3;
  localparam spi_state_t ST_GAP     = 3'd4;

  // Register addresses decoded by spi_peripheral; anything above is ignored.
  localparam logic [SPI_ADDR_W-1:0] SPI_REG_EN_OUT_7_0  = 7'h00;
  localparam logic [SPI_ADDR_W-1:0] SPI_REG_EN_OUT_15_8 = 7'h01;
  localparam logic [SPI_ADDR_W-1:0] SPI_REG_CFG_0       = 7'h02;
  localparam logic [SPI_ADDR_W-1:0] SPI_REG_CFG_1       = 7'h03;
  localparam logic [SPI_ADDR_W-1:0] SPI_REG_CFG_2       = 7'h04;
  localparam int                    SPI_REG_COUNT       = 5;

  function automatic logic [SPI_FRAME_W-1:0] spi_make_frame(
    input logic                  rw,
    input logic [SPI_ADDR_W-1:0] addr,
    input logic [SPI_DATA_W-1:0] data
  );
    return {rw, addr, data};
  endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// Phase timer for the SPI controller: a reloading down-counter that ticks on
// the last cycle of each period and is restarted on every FSM state entry.
module spi_clk_tick (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic [7:0] period,
  output logic       tick
);

  logic [7:0] cnt;

  // Loading period-1 makes the tick land on the period-th cycle of a state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (restart || cnt == 8'd0) begin
      cnt <= period - 8'd1;
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

  assign tick = (cnt == 8'd0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 master sending 16-bit {rw, addr, wdata} frames MSB first.
// Define SPI_CONTROLLER_READ_EN to add the CIPO input and rdata readback.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef SPI_CONTROLLER_READ_EN
  input  logic                  CIPO,
  output logic [SPI_DATA_W-1:0] rdata,
`endif
  input  logic                  start,
  input  logic                  rw,
  input  logic [SPI_ADDR_W-1:0] addr,
  input  logic [SPI_DATA_W-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  SCLK,
  output logic                  nCS,
  output logic                  COPI
);

  localparam logic [7:0]           DIV_P      = 8'(CLK_DIV);
  localparam logic [7:0]           GAP_P      = 8'(CS_GAP);
  localparam logic [SPI_CNT_W-1:0] LAST_BIT   = SPI_CNT_W'(SPI_FRAME_W);

  spi_state_t             state;
  spi_state_t             state_nxt;
  logic                   restart;
  logic                   tick;
  logic [7:0]             period;
  logic [SPI_FRAME_W-1:0] shreg;
  logic [SPI_CNT_W-1:0]   bit_cnt;

  // A start seen on the final GAP cycle chains straight into the next frame,
  // which keeps nCS high for exactly CS_GAP cycles when start is held.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_SETUP;
      ST_SETUP:   if (tick)  state_nxt = ST_SCLK_HI;
      ST_SCLK_HI: if (tick)  state_nxt = ST_SCLK_LO;
      ST_SCLK_LO: if (tick)  state_nxt = (bit_cnt == LAST_BIT) ? ST_GAP : ST_SCLK_HI;
      ST_GAP:     if (tick)  state_nxt = start ? ST_SETUP : ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  assign restart = (state_nxt != state);
  assign period  = (state_nxt == ST_GAP) ? GAP_P : DIV_P;

  spi_clk_tick u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .period  (period),
    .tick    (tick)
  );

  // Outputs are registered and change only on the cycle a new state begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      SCLK    <= 1'b0;
      nCS     <= 1'b1;
      COPI    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (restart) begin
        case (state_nxt)
          ST_SETUP: begin
            shreg   <= spi_make_frame(rw, addr, wdata);
            bit_cnt <= '0;
            nCS     <= 1'b0;
            COPI    <= rw;
            SCLK    <= 1'b0;
            busy    <= 1'b1;
          end
          ST_SCLK_HI: begin
            SCLK <= 1'b1;
          end
          ST_SCLK_LO: begin
            SCLK    <= 1'b0;
            COPI    <= shreg[SPI_FRAME_W-2];
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
          ST_GAP: begin
            nCS  <= 1'b1;
            COPI <= 1'b0;
            done <= 1'b1;
          end
          default: begin
            busy    <= 1'b0;
            bit_cnt <= '0;
          end
        endcase
      end
    end
  end

`ifdef SPI_CONTROLLER_READ_EN
  localparam logic [SPI_CNT_W-1:0] DATA_START = SPI_CNT_W'(SPI_FRAME_W - SPI_DATA_W);

  logic                  frame_rw;
  logic [SPI_DATA_W-1:0] rx_shift;

  // CIPO is captured on the last cycle of each data-phase SCLK high, i.e.
  // just before the falling edge; reads publish rdata together with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_rw <= 1'b0;
      rx_shift <= '0;
      rdata    <= '0;
    end else begin
      if (restart && state_nxt == ST_SETUP) begin
        frame_rw <= rw;
      end
      if (state == ST_SCLK_HI && tick && bit_cnt >= DATA_START) begin
        rx_shift <= {rx_shift[SPI_DATA_W-2:0], CIPO};
      end
      if (restart && state_nxt == ST_GAP && !frame_rw) begin
        rdata <= rx_shift;
      end
    end
  end
`endif

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range 2..255.
REQ-002 The block SHALL have parameter CS_GAP, default 8: minimum nCS-high time between transactions, in clk cycles; legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1: transaction request, sampled only when busy=0.
REQ-006 The block SHALL have port rw, input, 1: R/W bit; 1 = write.
REQ-007 The block SHALL have port addr, input, 7: register address.
REQ-008 The block SHALL have port wdata, input, 8: write data.
REQ-009 The block SHALL have port busy, output, 1: high from the cycle after start is accepted until the CS_GAP interval ends.
REQ-010 The block SHALL have port done, output, 1: one-cycle pulse on the cycle nCS returns high.
REQ-011 The block SHALL have port SCLK, output, 1: serial clock; idles low (mode 0).
REQ-012 The block SHALL have port nCS, output, 1: chip select, active low; idles high.
REQ-013 The block SHALL have port COPI, output, 1: serial data out, MSB first.

Function
REQ-014 The frame SHALL be the 16-bit word {rw, addr[6:0], wdata[7:0]}; bit 15 is transmitted first.
REQ-015 start with busy=0 at cycle T SHALL latch the frame; busy=1 and nCS=0 from T+1, with COPI = frame bit 15.
REQ-016 The FSM SHALL use states IDLE -> SETUP (CLK_DIV cycles) -> SCLK_HI (CLK_DIV) -> SCLK_LO (CLK_DIV), repeated 16 times, then -> GAP (CS_GAP) -> IDLE.
REQ-017 COPI SHALL change only on entry to SCLK_LO, never while SCLK is high; the receiver samples on the rising edge.
REQ-018 After the 16th SCLK_LO, nCS SHALL rise and done SHALL pulse for exactly 1 cycle.
REQ-019 With CLK_DIV=4 and CS_GAP=8, start at T SHALL give nCS low over T+1..T+132, nCS high and done=1 at T+133, busy=0 at T+141.
REQ-020 start while busy=1 SHALL be ignored, with no queuing.
REQ-021 A start asserted on the same cycle busy falls SHALL be accepted.
REQ-022 The 5-bit bit counter SHALL count 0..16 without wrap; no 17th SCLK pulse SHALL be generated.
REQ-023 Inputs rw, addr and wdata SHALL be ignored after latching.

Reset
REQ-024 While rst_n=0, the block SHALL hold nCS=1, SCLK=0, COPI=0, busy=0, done=0, FSM=IDLE, counters=0, asynchronously.
REQ-025 A reset mid-transaction SHALL abort the transaction immediately with no done pulse; the first start after release SHALL begin a clean frame.

Configuration
REQ-026 With macro SPI_CONTROLLER_READ_EN defined, the block SHALL add input CIPO (1 bit) and output rdata (8 bits, reset 0x00).
REQ-027 With SPI_CONTROLLER_READ_EN defined, CIPO SHALL be sampled at the end of each SCLK_HI during bits 7..0 of a rw=0 frame, and rdata SHALL update on the done cycle.
REQ-028 With SPI_CONTROLLER_READ_EN defined, rdata SHALL be unchanged by rw=1 frames.
REQ-029 Without SPI_CONTROLLER_READ_EN, the block SHALL have no CIPO or rdata ports and no read logic; write behaviour SHALL be identical in both builds.

Structure
REQ-030 Package spi_pkg SHALL hold the FSM state enum, SPI_FRAME_W=16, SPI_ADDR_W=7, SPI_DATA_W=8, and the register address constants 0x00-0x04 shared with spi_peripheral.
REQ-031 The block SHALL contain one sub-module, spi_clk_tick: a down-counter that emits a one-cycle tick every CLK_DIV cycles and is restarted by the FSM on each state entry.

Verification
REQ-032 Bench: rw=1, addr=0x04, wdata=0xAB -> COPI bits on SCLK rising edges = 0x84AB, 16 SCLK pulses, one done pulse.
REQ-033 Bench: DUT looped into spi_peripheral with a write of addr 0x00, data 0x5A -> EN_OUT_7_0=0x5A after the transaction; a write to addr 0x05 -> no register changes.
REQ-034 Bench: start re-pulsed at T+40 during a transfer -> ignored; exactly 16 SCLK pulses and one done pulse.
REQ-035 Bench: start held high continuously -> back-to-back frames with nCS high for exactly 8 cycles between them.
REQ-036 Bench: rst_n low at T+60 -> nCS=1 and SCLK=0 in the same cycle, no done pulse; the next start yields a full correct frame.
REQ-037 Bench (SPI_CONTROLLER_READ_EN): rw=0 with CIPO driving 0xC3 during the data phase -> rdata=0xC3 on the done cycle.
